// File: rtl/regfile_dump.sv
// regfile_dump: walks x0..x(NUM_REGS-1) through a dedicated regfile read port and streams each word out.
// Optional build macro REGDUMP_CHECKSUM_EN appends one beat carrying the XOR of all dumped words.
// Ports:
//   i_clk, i_reset (sync, active-low)      clock and reset
//   i_start                                one-cycle start request, honoured only when idle
//   o_busy                                 dump in progress (READ/SEND/CKSUM/DONE)
//   o_rs_addr / i_rs_data                  combinational regfile read port
//   o_dump_valid / i_dump_ready            beat handshake
//   o_dump_data, o_dump_idx, o_dump_last   beat payload, register index, final-beat flag
//   o_done                                 one-cycle pulse after the final beat handshakes
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_rs_addr,
  input  logic [DATA_W-1:0] i_rs_data,
  output logic              o_dump_valid,
  input  logic              i_dump_ready,
  output logic [DATA_W-1:0] o_dump_data,
  output logic [ADDR_W:0]   o_dump_idx,
  output logic              o_dump_last,
  output logic              o_done
);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(NUM_REGS - 1);
`ifdef REGDUMP_CHECKSUM_EN
  localparam logic [ADDR_W:0] CK_IDX = (ADDR_W+1)'(NUM_REGS);
  typedef enum logic [2:0] {IDLE, READ, SEND, CKSUM, DONE} state_t;
  logic [DATA_W-1:0] acc;
`else
  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;
`endif
  state_t state, state_n;
  logic [ADDR_W:0] idx;
  logic hs;
  assign hs = o_dump_valid && i_dump_ready;
  assign o_busy = state != IDLE;
  assign o_done = state == DONE;
  assign o_rs_addr = state == READ ? idx[ADDR_W-1:0] : '0;
`ifdef REGDUMP_CHECKSUM_EN
  assign o_dump_valid = state == SEND || state == CKSUM;
`else
  assign o_dump_valid = state == SEND;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = i_start ? READ : IDLE;
      READ: state_n = SEND;
`ifdef REGDUMP_CHECKSUM_EN
      SEND: state_n = hs ? (idx == LAST ? CKSUM : READ) : SEND;
      CKSUM: state_n = hs ? DONE : CKSUM;
`else
      SEND: state_n = hs ? (o_dump_last ? DONE : READ) : SEND;
`endif
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state       <= IDLE;
      idx         <= '0;
      o_dump_data <= '0;
      o_dump_idx  <= '0;
      o_dump_last <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      acc         <= '0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && i_start) idx <= '0;
      if (state == READ) begin
        o_dump_data <= i_rs_data;
        o_dump_idx  <= idx;
      end
      if (state == SEND && state_n == READ) idx <= idx + 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
      if (state == IDLE && i_start) acc <= '0;
      if (state == READ) acc <= acc ^ i_rs_data;
      // The checksum beat is loaded straight from the accumulator; it needs no regfile read cycle.
      if (state == SEND && state_n == CKSUM) begin
        idx         <= CK_IDX;
        o_dump_data <= acc;
        o_dump_idx  <= CK_IDX;
        o_dump_last <= 1'b1;
      end else if (state == READ) o_dump_last <= 1'b0;
`else
      if (state == READ) o_dump_last <= idx == LAST;
`endif
    end
  end
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: beat-level reference model and randomized stimulus for regfile_dump.
module tb_regfile_dump;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef REGDUMP_CHECKSUM_EN
  localparam int NB = NR + 1;
  localparam int DUMP_CYC = 66;
  localparam bit LAST31 = 1'b0;
`else
  localparam int NB = NR;
  localparam int DUMP_CYC = 65;
  localparam bit LAST31 = 1'b1;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ready = 1'b0;
  logic busy, valid, last, done;
  logic [AW-1:0] rs_addr;
  logic [DW-1:0] rs_data, ddata;
  logic [AW:0] didx;
  logic [DW-1:0] regs [NR];
  assign rs_data = regs[rs_addr];
  regfile_dump dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .o_busy(busy),
    .o_rs_addr(rs_addr), .i_rs_data(rs_data), .o_dump_valid(valid),
    .i_dump_ready(ready), .o_dump_data(ddata), .o_dump_idx(didx),
    .o_dump_last(last), .o_done(done)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0, n_done = 0, done_cyc = 0, start_cyc = 0;
  bit chk_en = 1'b0;
  bit m_busy = 1'b0, m_valid = 1'b0, m_done = 1'b0;
  int m_beat = 0;
  logic [DW-1:0] seen_data [NB];
  bit seen_last [NB];
  function automatic logic [DW-1:0] exp_data(input int b);
    logic [DW-1:0] x = '0;
    if (b < NR) return regs[b];
    for (int i = 0; i < NR; i++) x ^= regs[i];
    return x;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(posedge clk) cyc++;
  // Compare the DUT against the beat model every cycle, then advance the model across the coming edge.
  always @(negedge clk) if (chk_en) begin
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("valid", 64'(valid), 64'(m_valid));
    if (!m_busy) chk("rs_addr_idle", 64'(rs_addr), 64'd0);
    if (m_valid) begin
      chk("beat_idx", 64'(didx), 64'(m_beat));
      chk("beat_data", 64'(ddata), 64'(exp_data(m_beat)));
      chk("beat_last", 64'(last), 64'(m_beat == NB - 1));
      seen_data[m_beat] = ddata;
      seen_last[m_beat] = last;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (!rst_n) begin
      m_busy = 0; m_valid = 0; m_done = 0; m_beat = 0;
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end else if (!m_busy) begin
      if (start) begin m_busy = 1; m_beat = 0; end
    end else if (!m_valid) m_valid = 1;
    else if (ready) begin
      if (m_beat == NB - 1) begin m_valid = 0; m_done = 1; end
      else begin m_beat++; m_valid = (m_beat == NR); end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done(input int d0, input bit rnd);
    int n = 0;
    while (n_done == d0 && n < 2000) begin
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    ready = 1'b1;
    if (n_done == d0) begin
      errors++;
      $display("FAIL wait_done timeout got %0d expected %0d", n_done, d0 + 1);
    end
  endtask
  task automatic wait_beat(input int k);
    int n = 0;
    while (!(valid && didx == k) && n < 300) begin tick(); n++; end
    if (!(valid && didx == k)) begin
      errors++;
      $display("FAIL wait_beat timeout got %0d expected %0d", didx, k);
    end
  endtask
  initial begin
    int d0;
    for (int i = 0; i < NR; i++) regs[i] = '0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("reset_data", 64'(ddata), 64'd0);
    chk("reset_idx", 64'(didx), 64'd0);
    chk("reset_last", 64'(last), 64'd0);
    rst_n = 1'b1;
    repeat (20) tick();
    regs[1] = 32'hDEADBEEF;
    regs[31] = 32'hCAFEBABE;
    ready = 1'b1;
    d0 = n_done;
    pulse_start();
    wait_done(d0, 1'b0);
    chk("dump_latency", 64'(done_cyc - start_cyc), 64'(DUMP_CYC));
    chk("x1_literal", 64'(seen_data[1]), 64'hDEADBEEF);
    chk("x31_literal", 64'(seen_data[31]), 64'hCAFEBABE);
    chk("x31_last", 64'(seen_last[31]), 64'(LAST31));
`ifdef REGDUMP_CHECKSUM_EN
    chk("cksum_literal", 64'(seen_data[32]), 64'h14530451);
    chk("cksum_last", 64'(seen_last[32]), 64'd1);
`endif
    chk("one_done", 64'(n_done), 64'(d0 + 1));
    repeat (3) tick();
    regs[3] = 32'h3;
    d0 = n_done;
    pulse_start();
    wait_beat(3);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 64'(valid), 64'd1);
      chk("bp_data", 64'(ddata), 64'h3);
      chk("bp_idx", 64'(didx), 64'd3);
    end
    ready = 1'b1;
    tick();
    tick();
    chk("bp_next_idx", 64'(didx), 64'd4);
    wait_done(d0, 1'b0);
    d0 = n_done;
    pulse_start();
    wait_beat(10);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(d0, 1'b0);
    repeat (20) tick();
    chk("busy_start_one_done", 64'(n_done), 64'(d0 + 1));
    d0 = n_done;
    pulse_start();
    wait_beat(7);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midreset_valid", 64'(valid), 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    repeat (5) tick();
    chk("midreset_no_done", 64'(n_done), 64'(d0));
    pulse_start();
    tick();
    chk("restart_idx0", 64'(didx), 64'd0);
    wait_done(d0, 1'b0);
    start = 1'b1;
    rst_n = 1'b0;
    tick();
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("start_reset_busy", 64'(busy), 64'd0);
    for (int t = 0; t < 4; t++) begin
      for (int i = 1; i < NR; i++) regs[i] = $urandom;
      d0 = n_done;
      pulse_start();
      wait_done(d0, 1'b1);
      repeat (int'($urandom_range(0, 3))) tick();
    end
    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Debug readout engine on the read side of the 32x32 RISC-V register file.
- On a start pulse it walks addresses x0..x31 through one regfile read port.
- Each word is streamed out over a valid/ready handshake toward the debug/trace path.
- The processor keeps its own two read ports; this block uses a dedicated third read port, combinational, with the same semantics as rs1/rs2.

Parameters:
- NUM_REGS, 32, number of registers walked (indices 0..NUM_REGS-1).
- ADDR_W, 5, regfile address width.
- DATA_W, 32, register data width.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_reset  input  1  synchronous, active-low reset.
- i_start  input  1  one-cycle start request; sampled only in IDLE.
- o_busy  output  1  high from the cycle after an accepted start until DONE exits.
- o_rs_addr  output  ADDR_W  address to the regfile dump read port.
- i_rs_data  input  DATA_W  combinational read data for o_rs_addr.
- o_dump_valid  output  1  beat valid.
- i_dump_ready  input  1  sink ready.
- o_dump_data  output  DATA_W  beat payload.
- o_dump_idx  output  ADDR_W+1  register index of the beat.
- o_dump_last  output  1  marks the final beat of a dump.
- o_done  output  1  one-cycle pulse after the final beat handshakes.

Behaviour:
- Clock and reset: single clock i_clk. Reset is synchronous, active-low, on i_reset; i_reset=0 at a rising edge resets all state.
- Reset values:
  - state=IDLE, idx=0.
  - o_busy=0, o_rs_addr=0, o_dump_valid=0, o_dump_data=0, o_dump_idx=0, o_dump_last=0, o_done=0.
  - checksum accumulator=0.
- FSM states: IDLE, READ, SEND, DONE.
- IDLE:
  - o_rs_addr=0.
  - i_start=1 moves to READ and clears idx and the accumulator.
- READ (exactly 1 cycle):
  - o_rs_addr=idx[ADDR_W-1:0].
  - At the edge: o_dump_data<=i_rs_data, o_dump_idx<=idx, o_dump_last<=(idx==NUM_REGS-1 and no checksum beat follows), accumulator^=i_rs_data, state<=SEND.
- SEND:
  - o_dump_valid=1.
  - o_dump_data, o_dump_idx and o_dump_last stay stable until o_dump_valid and i_dump_ready are both high at an edge.
  - On handshake, if not the last beat: idx<=idx+1, go to READ.
  - On handshake of the last beat: go to DONE.
  - o_dump_valid deasserts the cycle after the handshake.
- DONE (1 cycle): o_done=1, o_busy=0 next cycle, return to IDLE.
- Throughput and latency:
  - 2 cycles per beat minimum.
  - First beat valid 2 cycles after the start edge.
  - A full dump with no backpressure takes 2*NUM_REGS+1 cycles from start to o_done.
- Coherency: each word is sampled in its own READ cycle. No snapshot guarantee across the dump; concurrent core writes may be partially visible.
- Boundary conditions:
  - i_start while busy is ignored, with no restart or queueing.
  - i_start and reset in the same cycle: reset wins.
  - i_dump_ready may be high before valid; no combinational path from ready to valid.
  - x0 is read through the regfile like any other index and reports whatever the port returns (0 per RISC-V).
  - Reset mid-dump: next cycle IDLE, valid=0, no o_done, partial dump abandoned.
  - idx never wraps; it stops at NUM_REGS-1 (NUM_REGS with checksum).

Optional Feature:
- Macro REGDUMP_CHECKSUM_EN.
- Defined:
  - After the x(NUM_REGS-1) beat, one extra beat is sent through a CKSUM state that behaves like SEND.
  - The extra beat carries o_dump_data = XOR of all NUM_REGS words, o_dump_idx=NUM_REGS, o_dump_last=1.
  - o_dump_last is 0 on the x31 beat.
  - Full dump takes 2*NUM_REGS+2 cycles with no backpressure.
- Undefined:
  - No accumulator logic.
  - The x(NUM_REGS-1) beat carries o_dump_last=1.
  - o_dump_idx MSB is always 0.

Test Plan:
- Reset then idle: i_reset=0 for 2 cycles, then 1, no start. Expect all outputs 0, o_rs_addr=0, no valid for 20 cycles.
- Full dump, no backpressure: model x1=DEADBEEF, x31=CAFEBABE, others 0; i_dump_ready=1; pulse i_start.
  - Expect 32 beats with idx 0..31 in order; idx1=DEADBEEF; idx31=CAFEBABE with last=1.
  - Expect o_done exactly 65 cycles after the start edge.
- Checksum (REGDUMP_CHECKSUM_EN): same preload. Expect 33 beats; beat idx 32 data=14530451 with last=1; idx31 has last=0.
- Backpressure: hold i_dump_ready=0 for 5 cycles while idx3 (value 0000_0003 preloaded) is valid. Expect data/idx stable and valid held; handshake on ready's return; next beat idx4.
- Start while busy: pulse i_start at beat idx10. Expect the dump to continue unaffected, exactly one o_done, and no second dump.
- Reset mid-dump: assert i_reset at beat idx7. Expect valid=0 and busy=0 next cycle, no o_done; a subsequent start restarts at idx0.
